ball_controller: RTL and testbench

BALL_CONTROLLER -- requirements
Module: ball_controller

---
 rtl/ball_controller.sv | 174 +++++++++++++++++
 tb/tb_ball_controller.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/ball_controller.sv
// Pong ball/score engine: serves, moves and bounces the ball once per frame tick,
// detects paddle hits and misses, and keeps score until one side reaches WIN_SCORE.
module ball_controller #(
  parameter int unsigned BALL_SIZE    = 8,
  parameter int unsigned SPEED        = 2,
  parameter int unsigned P1_EDGE      = 40,
  parameter int unsigned P2_EDGE      = 600,
  parameter int unsigned PADDLE_H     = 72,
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned WIN_SCORE    = 9
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic [9:0] paddle1_y,
  input  logic [9:0] paddle2_y,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [3:0] score_1,
  output logic [3:0] score_2,
  output logic       point_pulse,
  output logic       serving,
  output logic       game_over
);

  localparam int unsigned CW = $clog2(SERVE_FRAMES + 1);
  localparam logic [9:0] SERVE_X = 10'd316;
  localparam logic [9:0] SERVE_Y = 10'd236;
  localparam logic signed [10:0] BS   = 11'(BALL_SIZE);
  localparam logic signed [10:0] SPD  = 11'(SPEED);
  localparam logic signed [10:0] P1   = 11'(P1_EDGE);
  localparam logic signed [10:0] P2   = 11'(P2_EDGE);
  localparam logic signed [10:0] XMAX = 11'sd640;
  localparam logic signed [10:0] YMAX = 11'sd480;
  localparam logic [3:0] WIN = 4'(WIN_SCORE);

  typedef enum logic [1:0] {S_SERVE, S_PLAY, S_SCORED, S_OVER} state_t;

  state_t          state_q, state_d;
  logic [9:0]      ball_x_q, ball_x_d, ball_y_q, ball_y_d;
  logic            dx_q, dx_d, dy_q, dy_d;  // dx: 1 = right, dy: 1 = down
  logic [3:0]      score_1_q, score_1_d, score_2_q, score_2_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            pp_q, pp_d;
  logic            armed_q;

  logic               tick;
  logic signed [10:0] bx, by, nx, ny;
  logic [10:0]        by_u, p1_u, p2_u;
  logic               ov1, ov2, hit1, hit2, miss_l, miss_r;

  // armed_q drops the tick that lands on the first edge after reset release
  assign tick = frame_tick & armed_q;

  assign bx = $signed({1'b0, ball_x_q});
  assign by = $signed({1'b0, ball_y_q});
  assign nx = dx_q ? bx + SPD : bx - SPD;
  assign ny = dy_q ? by + SPD : by - SPD;

  assign by_u = {1'b0, ball_y_q};
  assign p1_u = {1'b0, paddle1_y};
  assign p2_u = {1'b0, paddle2_y};
  assign ov1  = (by_u + 11'(BALL_SIZE) > p1_u) && (by_u < p1_u + 11'(PADDLE_H));
  assign ov2  = (by_u + 11'(BALL_SIZE) > p2_u) && (by_u < p2_u + 11'(PADDLE_H));

  assign hit1   = !dx_q && (bx >= P1) && (nx <= P1) && ov1;
  assign hit2   = dx_q && (bx + BS <= P2) && (nx + BS >= P2) && ov2;
  assign miss_l = !dx_q && (nx <= 11'sd0) && !hit1;
  assign miss_r = dx_q && (nx + BS >= XMAX) && !hit2;

  always_comb begin
    state_d   = state_q;
    ball_x_d  = ball_x_q;
    ball_y_d  = ball_y_q;
    dx_d      = dx_q;
    dy_d      = dy_q;
    score_1_d = score_1_q;
    score_2_d = score_2_q;
    cnt_d     = cnt_q;
    pp_d      = 1'b0;

    if (tick) begin
      unique case (state_q)
        S_SERVE: begin
          if (cnt_q == CW'(SERVE_FRAMES - 1)) begin
            state_d = S_PLAY;
            dy_d    = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_PLAY: begin
          // A miss freezes the ball where it was; the serve direction points at the loser.
          if (miss_l) begin
            if (score_2_q < WIN) score_2_d = score_2_q + 4'd1;
            dx_d    = 1'b0;
            pp_d    = 1'b1;
            state_d = S_SCORED;
          end else if (miss_r) begin
            if (score_1_q < WIN) score_1_d = score_1_q + 4'd1;
            dx_d    = 1'b1;
            pp_d    = 1'b1;
            state_d = S_SCORED;
          end else begin
            if (ny <= 11'sd0) begin
              ball_y_d = '0;
              dy_d     = 1'b1;
            end else if (ny + BS >= YMAX) begin
              ball_y_d = 10'(YMAX - BS);
              dy_d     = 1'b0;
            end else begin
              ball_y_d = ny[9:0];
            end
            if (hit1) begin
              ball_x_d = P1[9:0];
              dx_d     = 1'b1;
            end else if (hit2) begin
              ball_x_d = 10'(P2 - BS);
              dx_d     = 1'b0;
            end else begin
              ball_x_d = nx[9:0];
            end
          end
        end
        S_SCORED: begin
          if (score_1_q == WIN || score_2_q == WIN) begin
            state_d = S_OVER;
          end else begin
            state_d  = S_SERVE;
            cnt_d    = '0;
            ball_x_d = SERVE_X;
            ball_y_d = SERVE_Y;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_SERVE;
      ball_x_q  <= SERVE_X;
      ball_y_q  <= SERVE_Y;
      dx_q      <= 1'b1;
      dy_q      <= 1'b1;
      score_1_q <= '0;
      score_2_q <= '0;
      cnt_q     <= '0;
      pp_q      <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ball_x_q  <= ball_x_d;
      ball_y_q  <= ball_y_d;
      dx_q      <= dx_d;
      dy_q      <= dy_d;
      score_1_q <= score_1_d;
      score_2_q <= score_2_d;
      cnt_q     <= cnt_d;
      pp_q      <= pp_d;
      armed_q   <= 1'b1;
    end
  end

  assign ball_x      = ball_x_q;
  assign ball_y      = ball_y_q;
  assign score_1     = score_1_q;
  assign score_2     = score_2_q;
  assign point_pulse = pp_q;
  assign serving     = (state_q == S_SERVE);
  assign game_over   = (state_q == S_OVER);

endmodule

// File: tb/tb_ball_controller.sv
// Directed bench for ball_controller: serve timing, wall/paddle bounces, misses,
// game end and asynchronous reset, with hand-computed expectations.
module tb_ball_controller;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic [9:0] paddle1_y = '0;
  logic [9:0] paddle2_y = '0;
  logic [9:0] ball_x, ball_y;
  logic [3:0] score_1, score_2;
  logic       point_pulse, serving, game_over;

  int n_cmp = 0;
  int n_err = 0;

  ball_controller #(
    .BALL_SIZE(8), .SPEED(2), .P1_EDGE(40), .P2_EDGE(600),
    .PADDLE_H(72), .SERVE_FRAMES(60), .WIN_SCORE(9)
  ) dut (
    .clock(clock), .reset(reset), .frame_tick(frame_tick),
    .paddle1_y(paddle1_y), .paddle2_y(paddle2_y),
    .ball_x(ball_x), .ball_y(ball_y),
    .score_1(score_1), .score_2(score_2),
    .point_pulse(point_pulse), .serving(serving), .game_over(game_over)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
    frame_tick = 1'b1;
    @(negedge clock);
    frame_tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Places the ball mid-play; only valid while the FSM is in PLAY.
  task automatic load(input int x, input int y, input logic dx, input logic dy);
    dut.ball_x_q = 10'(x);
    dut.ball_y_q = 10'(y);
    dut.dx_q     = dx;
    dut.dy_q     = dy;
  endtask

  task automatic chk_ball(input string tag, input int x, input int y);
    chk({tag, "_x"}, int'(ball_x), x);
    chk({tag, "_y"}, int'(ball_y), y);
  endtask

  task automatic chk_reset_state(input string tag);
    chk_ball(tag, 316, 236);
    chk({tag, "_s1"}, int'(score_1), 0);
    chk({tag, "_s2"}, int'(score_2), 0);
    chk({tag, "_srv"}, int'(serving), 1);
    chk({tag, "_pp"}, int'(point_pulse), 0);
    chk({tag, "_go"}, int'(game_over), 0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic got;

    // Reset state, then release with a tick on the same edge (must be ignored)
    repeat (2) @(negedge clock);
    chk_reset_state("rst");
    frame_tick = 1'b1;
    reset      = 1'b0;
    @(negedge clock);
    frame_tick = 1'b0;
    ticks(59);
    chk("serve59_srv", int'(serving), 1);
    tick();
    chk("serve60_srv", int'(serving), 0);
    chk_ball("serve60", 316, 236);
    repeat (3) @(negedge clock);
    chk_ball("hold", 316, 236);
    chk("hold_srv", int'(serving), 0);
    tick();
    chk_ball("serve61", 318, 238);

    // Top wall
    load(300, 1, 1'b1, 1'b0);
    tick();
    chk_ball("top1", 302, 0);
    tick();
    chk_ball("top2", 304, 2);

    // Bottom wall
    load(300, 470, 1'b1, 1'b1);
    tick();
    chk_ball("bot1", 302, 472);
    tick();
    chk_ball("bot2", 304, 470);

    // Left paddle hit
    paddle1_y = 10'd80;
    load(41, 100, 1'b0, 1'b1);
    tick();
    chk_ball("lhit1", 40, 102);
    chk("lhit_pp", int'(point_pulse), 0);
    tick();
    chk_ball("lhit2", 42, 104);
    chk("lhit_s2", int'(score_2), 0);

    // Ball bottom row only touches paddle top row: no hit
    paddle1_y = 10'd108;
    load(41, 100, 1'b0, 1'b1);
    tick();
    chk_ball("corner", 39, 102);

    // Right paddle hit
    paddle2_y = 10'd80;
    load(590, 100, 1'b1, 1'b1);
    tick();
    chk_ball("rhit1", 592, 102);
    tick();
    chk_ball("rhit2", 590, 104);

    // Wall and paddle in the same tick
    paddle1_y = 10'd0;
    load(41, 1, 1'b0, 1'b0);
    tick();
    chk_ball("both1", 40, 0);
    tick();
    chk_ball("both2", 42, 2);

    // Left miss: x 41 -> 1 takes 20 ticks, the 21st declares the miss
    paddle1_y = 10'd0;
    load(41, 200, 1'b0, 1'b1);
    n = 0;
    got = 1'b0;
    while (n < 40 && !got) begin
      tick();
      n++;
      got = point_pulse;
    end
    chk("lmiss_ticks", n, 21);
    chk("lmiss_s2", int'(score_2), 1);
    chk("lmiss_s1", int'(score_1), 0);
    @(negedge clock);
    chk("lmiss_pp_off", int'(point_pulse), 0);
    tick();
    chk("lmiss_srv", int'(serving), 1);
    chk_ball("lmiss_ctr", 316, 236);
    ticks(60);
    tick();
    chk_ball("serve_left", 314, 238);

    // Game end on a right miss with score_1 at 8
    dut.score_1_q = 4'd8;
    load(631, 100, 1'b1, 1'b1);
    tick();
    chk("end_pp", int'(point_pulse), 1);
    chk("end_s1", int'(score_1), 9);
    tick();
    chk("end_go", int'(game_over), 1);
    chk_ball("end_frz", 631, 100);
    ticks(3);
    chk_ball("end_frz3", 631, 100);
    chk("end_go3", int'(game_over), 1);
    chk("end_s1_3", int'(score_1), 9);

    // Asynchronous reset while in OVER
    @(negedge clock);
    #2 reset = 1'b1;
    #1 chk_reset_state("rst_over");
    @(negedge clock);
    reset = 1'b0;

    // Asynchronous reset mid-PLAY
    ticks(65);
    chk_ball("pre_rst", 326, 246);
    #3 reset = 1'b1;
    #1 chk_reset_state("rst_play");
    do_reset();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
